riscv_data_mem: RTL

Multi-cycle data memory that acts as the responder on the core's memory interface. It sits behind the load-store unit and serves one request at a time. It applies byte-enabled writes to an internal word array. For each request it returns read data together with a single-cycle ready pulse after a fixed, parameterised latency, so the core's stall logic sees a real multi-cycle memory.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/riscv_be_ram.sv | 53 +++++
 rtl/riscv_data_mem.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the core's memory-side blocks.
//   mem_state_t : responder FSM states for riscv_data_mem
//   mem_txn_t   : captured request payload (direction, byte enables, write data)
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_READY = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wd;
   } mem_txn_t;

endpackage

// File: rtl/riscv_be_ram.sv
// riscv_be_ram: DEPTH_WORDS x 32 storage with one byte-enabled write port
// and one synchronous, enabled read port. Contents are never reset; only
// the read data register is.
//   clk_i, rst_i : clock, synchronous active-high reset (read register only)
//   we_i, be_i   : write strobe and per-lane byte enables
//   waddr_i      : write word index
//   wd_i         : write data
//   re_i         : read strobe; rd_o updates on the following edge
//   raddr_i      : read word index
//   rd_o         : registered read data, held until the next read
module riscv_be_ram
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            we_i,
   input  logic [BE_W-1:0] be_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wd_i,
   input  logic            re_i,
   input  logic [AW-1:0]   raddr_i,
   output logic [XLEN-1:0] rd_o
);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] rd_q;

   // Byte-lane write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int n = 0; n < int'(BE_W); n++) begin
            if (be_i[n]) begin
               mem_q[waddr_i][8*n +: 8] <= wd_i[8*n +: 8];
            end
         end
      end
   end

   // Synchronous read port; output holds between reads
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q <= '0;
      end else if (re_i) begin
         rd_q <= mem_q[raddr_i];
      end
   end

   assign rd_o = rd_q;

endmodule

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: multi-cycle data memory responder. Serves one request at a
// time and pulses mem_ready_o exactly LATENCY cycles after acceptance.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   mem_req_i     : request valid, held by the initiator until mem_ready_o
//   mem_we_i      : 1 = write, 0 = read
//   mem_be_i      : write byte enables
//   mem_addr_i    : byte address; word index taken from [AW+1:2]
//   mem_wd_i      : lane-replicated write data
//   mem_rd_o      : read data, updated only on read completion
//   mem_ready_o   : one-cycle completion pulse
module riscv_data_mem
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            mem_req_i,
   input  logic            mem_we_i,
   input  logic [BE_W-1:0] mem_be_i,
   input  logic [XLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_wd_i,
   output logic [XLEN-1:0] mem_rd_o,
   output logic            mem_ready_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   // Parameter legality
   if (LATENCY < 1) begin : g_bad_latency
      $error("riscv_data_mem: LATENCY must be >= 1");
   end
   if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) || (AW > 30)) begin : g_bad_depth
      $error("riscv_data_mem: DEPTH_WORDS must be a power of two in [2, 2^30]");
   end

   mem_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   mem_txn_t        txn_q, txn_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            ready_q, ready_d;
   logic            ram_we_c, ram_re_c;
   logic            unused_addr_c;

   // Upper address bits and the byte offset are deliberately ignored
   assign unused_addr_c = ^{mem_addr_i[XLEN-1:AW+2], mem_addr_i[1:0]};

   // Next-state, capture and RAM strobe logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      txn_d    = txn_q;
      idx_d    = idx_q;
      ready_d  = 1'b0;
      ram_we_c = 1'b0;
      ram_re_c = 1'b0;

      case (state_q)
         MEM_IDLE: begin
            if (mem_req_i) begin
               txn_d.we = mem_we_i;
               txn_d.be = mem_be_i;
               txn_d.wd = mem_wd_i;
               idx_d    = mem_addr_i[AW+1:2];
               cnt_d    = CNT_LOAD;
               state_d  = (LATENCY == 1) ? MEM_READY : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            // Leave on the edge where the decremented count reaches zero
            if (cnt_q <= CW'(1)) begin
               cnt_d   = '0;
               state_d = MEM_READY;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         MEM_READY: begin
            // The still-visible request is the one completing; never re-accept
            state_d = MEM_IDLE;
         end
         default: begin
            state_d = MEM_IDLE;
         end
      endcase

      ready_d = (state_d == MEM_READY);
      // Read data is fetched on the edge entering MEM_READY
      ram_re_c = (state_d == MEM_READY) && !txn_d.we && !rst_i;
      // Write commits on the edge leaving MEM_READY, so a following read sees it
      ram_we_c = (state_q == MEM_READY) && txn_q.we && !rst_i;
   end

   // State, counter and capture registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         txn_q   <= '0;
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         txn_q   <= txn_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
      end
   end

   riscv_be_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (ram_we_c),
      .be_i    (txn_q.be),
      .waddr_i (idx_q),
      .wd_i    (txn_q.wd),
      .re_i    (ram_re_c),
      .raddr_i (idx_d),
      .rd_o    (mem_rd_o)
   );

   assign mem_ready_o = ready_q;

endmodule
